// File: rtl/if_stage_prefetch.sv
// Instruction-fetch prefetcher: credit-limited in-order requests, response FIFO to ID, branch flush.
// Latency: response to id_valid one cycle; backpressure: id_ready=0 fills the output FIFO, then imem_req drops.

module if_stage_prefetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic [CW-1:0] cnt_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; a write while full is only legal alongside a pop of the same slot.
  always_ff @(posedge clk) begin
    if (push_i && !clr_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o = mem_q[rd_ptr_q];
  assign cnt_o  = cnt_q;

endmodule

module if_stage_prefetch #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_instr
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 2;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] instr;
  } out_ent_t;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]     disc_q, disc_d;
  logic [CW-1:0]     pend_cnt, occ;
  logic [ADDR_W-1:0] pend_pc;
  out_ent_t          out_din, out_head;
  logic              credit_ok, any_fly, resp, fire, keep, id_pop;

  // Every granted request owns a future output slot, so kept responses never overflow.
  assign credit_ok = (SW'(pend_cnt) + SW'(disc_q) + SW'(occ)) < SW'(DEPTH);
  assign any_fly   = (pend_cnt != '0) || (disc_q != '0);
  assign resp      = imem_rvalid && any_fly;
  assign imem_req  = rst && !br_taken && credit_ok;
  assign imem_addr = fetch_pc_q;
  assign fire      = imem_req && imem_gnt;
  assign keep      = resp && !br_taken && (disc_q == '0);
  assign id_valid  = rst && !br_taken && (occ != '0);
  assign id_pop    = id_valid && id_ready;

  assign out_din.pc    = pend_pc;
  assign out_din.instr = imem_rdata;
  assign id_pc         = out_head.pc;
  assign id_instr      = out_head.instr;

  if_stage_prefetch_fifo #(.W(ADDR_W), .DEPTH(DEPTH)) u_pend_fifo (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (br_taken),
    .push_i (fire),
    .din_i  (fetch_pc_q),
    .pop_i  (keep),
    .dout_o (pend_pc),
    .cnt_o  (pend_cnt)
  );

  if_stage_prefetch_fifo #(.W($bits(out_ent_t)), .DEPTH(DEPTH)) u_out_fifo (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (br_taken),
    .push_i (keep),
    .din_i  (out_din),
    .pop_i  (id_pop),
    .dout_o (out_head),
    .cnt_o  (occ)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    disc_d     = disc_q;
    if (br_taken) begin
      // Everything still in flight becomes garbage, minus a response landing this very cycle.
      fetch_pc_d = br_target;
      disc_d     = pend_cnt + disc_q - CW'(resp);
    end else begin
      if (fire) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      if (resp && (disc_q != '0)) disc_d = disc_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      disc_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      disc_q     <= disc_d;
    end
  end

endmodule

// File: tb/tb_if_stage_prefetch.sv
// Randomized bench for if_stage_prefetch with a queue-based reference model plus directed scenarios.
// A second instance with an 8-bit address checks PC wrap-around.

module tb_if_stage_prefetch;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  logic        w_req, w_vld;
  logic [7:0]  w_addr, w_pc;
  logic [31:0] w_instr;
  logic        w_gnt = 1'b0;
  logic        w_rv = 1'b0;
  logic [31:0] w_rdata = '0;
  logic        w_ready = 1'b0;

  if_stage_prefetch u_dut (
    .clk(clk), .rst(rst), .br_taken(br_taken), .br_target(br_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr)
  );

  if_stage_prefetch #(.ADDR_W(8), .RESET_PC(8'hF8)) u_wrap (
    .clk(clk), .rst(rst), .br_taken(1'b0), .br_target(8'h00),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
    .imem_rvalid(w_rv), .imem_rdata(w_rdata),
    .id_valid(w_vld), .id_ready(w_ready), .id_pc(w_pc), .id_instr(w_instr)
  );

  typedef struct { logic [31:0] addr; int due; bit keep; } fly_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  // Reference model: everything granted but not yet answered, and everything waiting for ID.
  fly_t        fly[$];
  ent_t        outq[$];
  logic [31:0] m_pc = '0;
  int          cyc = 0;

  logic [31:0] grants[$];
  logic [31:0] pops[$];
  int          pop_cyc[$];

  int errors = 0;
  int checks = 0;

  int gnt_mode = 0, resp_mode = 0, ready_mode = 0, lat = 1, br_rate = 0;
  bit force_br = 0, stale_inj = 0;
  logic [31:0] force_tgt = '0;

  function automatic logic [31:0] mk(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  function automatic bit exp_req();
    return rst && !br_taken && (fly.size() + outq.size() < DEPTH);
  endfunction

  function automatic bit exp_vld();
    return rst && !br_taken && (outq.size() > 0);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial forever begin : model_update
    bit rq, vl, resp;
    fly_t h;
    ent_t e;
    @(posedge clk or negedge rst);
    if (!rst) begin
      fly.delete();
      outq.delete();
      m_pc = '0;
    end else begin
      rq   = exp_req();
      vl   = exp_vld();
      resp = imem_rvalid && (fly.size() > 0);
      if (br_taken) begin
        if (resp) h = fly.pop_front();
        foreach (fly[i]) fly[i].keep = 1'b0;
        outq.delete();
        m_pc = br_target;
      end else begin
        if (vl && id_ready) e = outq.pop_front();
        if (resp) begin
          h = fly.pop_front();
          if (h.keep) begin
            e.pc = h.addr;
            e.instr = imem_rdata;
            outq.push_back(e);
          end
        end
        if (rq && imem_gnt) begin
          h.addr = m_pc;
          h.due  = cyc + ((lat > 0) ? lat : int'($urandom_range(1, 4)));
          h.keep = 1'b1;
          fly.push_back(h);
          m_pc = m_pc + 32'd4;
        end
      end
      cyc++;
    end
  end

  initial forever begin : compare
    bit rq, vl;
    @(negedge clk);
    if (rst) begin
      rq = exp_req();
      vl = exp_vld();
      chk("imem_req", imem_req, rq);
      chk("imem_addr", imem_addr, m_pc);
      chk("id_valid", id_valid, vl);
      if (vl) begin
        chk("id_pc", id_pc, outq[0].pc);
        chk("id_instr", id_instr, outq[0].instr);
      end
      if (imem_req && imem_gnt) grants.push_back(imem_addr);
      if (id_valid && id_ready) begin
        pops.push_back(id_pc);
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic drive();
    bit ok;
    br_taken = force_br || (br_rate > 0 && $urandom_range(0, 99) < br_rate);
    if (force_br) br_target = force_tgt;
    else if ($urandom_range(0, 3) == 0) br_target = 32'hFFFF_FFF0;
    else br_target = $urandom & 32'h0000_FFFC;
    case (gnt_mode)
      0: imem_gnt = 1'b0;
      1: imem_gnt = 1'b1;
      2: imem_gnt = ($urandom_range(0, 99) < 60);
      default: imem_gnt = (m_pc < 32'd16);
    endcase
    ok = 1'b0;
    if (fly.size() > 0) ok = (fly[0].due <= cyc);
    case (resp_mode)
      0: imem_rvalid = 1'b0;
      1: imem_rvalid = ok;
      2: imem_rvalid = ok && ($urandom_range(0, 99) < 70);
      default: imem_rvalid = ok ? (fly[0].addr < 32'd8) : 1'b0;
    endcase
    if (stale_inj) begin
      imem_rvalid = 1'b1;
      imem_rdata  = $urandom;
    end else begin
      imem_rdata = imem_rvalid ? mk(fly[0].addr) : $urandom;
    end
    case (ready_mode)
      0: id_ready = 1'b0;
      1: id_ready = 1'b1;
      default: id_ready = ($urandom_range(0, 99) < 70);
    endcase
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      drive();
    end
  endtask

  task automatic idle();
    gnt_mode = 0; resp_mode = 0; ready_mode = 0; br_rate = 0; lat = 1;
    force_br = 0; stale_inj = 0;
  endtask

  task automatic clear_logs();
    grants.delete();
    pops.delete();
    pop_cyc.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    drive();
    #2;
    rst = 1'b0;
    clear_logs();
    @(posedge clk);
    #3;
    rst = 1'b1;
  endtask

  task automatic setup_two_fly_two_out(input int rdy);
    idle();
    do_reset();
    gnt_mode = 3; resp_mode = 3; lat = 1; ready_mode = rdy;
    run(8);
  endtask

  logic [31:0] wpops[$];
  logic [31:0] winstr[$];
  bit          w_nxt;
  logic [7:0]  w_naddr;
  logic [7:0]  wexp[4];
  int          n0;

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_vld", id_valid, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_waddr", w_addr, 8'hF8);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 32'h0);

    // Streaming at full rate.
    clear_logs();
    gnt_mode = 1; resp_mode = 1; lat = 1; ready_mode = 1;
    run(14);
    chk("stream_count", pops.size() >= 8, 1'b1);
    for (int i = 0; i < 8 && i < pops.size(); i++) begin
      chk("stream_pc", pops[i], 32'(4 * i));
      if (i > 0) chk("stream_bubble", pop_cyc[i] - pop_cyc[i-1], 1);
    end

    // ID stalled: credit exhausts after DEPTH grants.
    idle();
    do_reset();
    gnt_mode = 1; resp_mode = 1; lat = 1; ready_mode = 0;
    run(10);
    #1;
    chk("bp_grants", grants.size(), DEPTH);
    chk("bp_req", imem_req, 1'b0);
    chk("bp_vld", id_valid, 1'b1);
    chk("bp_pc", id_pc, 32'h0);
    chk("bp_instr", id_instr, mk(32'h0));
    clear_logs();
    ready_mode = 1;
    run(6);
    chk("bp_drain_count", pops.size() >= 4, 1'b1);
    for (int i = 0; i < 4 && i < pops.size(); i++) begin
      chk("bp_drain_pc", pops[i], 32'(4 * i));
      if (i > 0) chk("bp_drain_gap", pop_cyc[i] - pop_cyc[i-1], 1);
    end
    chk("bp_resume_count", grants.size() >= 1, 1'b1);
    if (grants.size() >= 1) chk("bp_resume_addr", grants[0], 32'd16);

    // Branch with 8 and 12 still in flight.
    setup_two_fly_two_out(1);
    chk("fl_fly_n", fly.size(), 2);
    if (fly.size() == 2) begin
      chk("fl_fly0", fly[0].addr, 32'd8);
      chk("fl_fly1", fly[1].addr, 32'd12);
    end
    resp_mode = 0; force_br = 1; force_tgt = 32'h100;
    run(1);
    force_br = 0; gnt_mode = 1; resp_mode = 1;
    run(12);
    chk("fl_count", pops.size() >= 4, 1'b1);
    if (pops.size() >= 4) begin
      chk("fl_pop0", pops[0], 32'h0);
      chk("fl_pop1", pops[1], 32'h4);
      chk("fl_pop2", pops[2], 32'h100);
      chk("fl_pop3", pops[3], 32'h104);
    end

    // Branch coinciding with a response and id_ready while the output FIFO holds data.
    setup_two_fly_two_out(0);
    chk("sim_occ", outq.size(), 2);
    n0 = pops.size();
    resp_mode = 1; ready_mode = 1; force_br = 1; force_tgt = 32'h200;
    run(1);
    #1;
    chk("sim_vld", id_valid, 1'b0);
    chk("sim_req", imem_req, 1'b0);
    force_br = 0;
    run(1);
    chk("sim_disc_n", fly.size(), 1);
    if (fly.size() == 1) chk("sim_disc_keep", fly[0].keep, 1'b0);
    chk("sim_nopop", pops.size(), n0);
    gnt_mode = 1;
    run(10);
    chk("sim_next_count", pops.size() > n0, 1'b1);
    if (pops.size() > n0) chk("sim_next_pc", pops[n0], 32'h200);

    // Asynchronous reset with requests outstanding and data queued.
    setup_two_fly_two_out(0);
    chk("rr_fly", fly.size(), 2);
    chk("rr_occ", outq.size(), 2);
    #2;
    rst = 1'b0;
    #1;
    chk("rr_vld", id_valid, 1'b0);
    chk("rr_req", imem_req, 1'b0);
    chk("rr_addr", imem_addr, 32'h0);
    idle();
    ready_mode = 1;
    drive();
    @(posedge clk);
    #3;
    rst = 1'b1;
    clear_logs();
    stale_inj = 1;
    run(3);
    #1;
    chk("rr_stale_vld", id_valid, 1'b0);
    chk("rr_stale_req", imem_req, 1'b1);
    chk("rr_stale_addr", imem_addr, 32'h0);
    stale_inj = 0; gnt_mode = 1; resp_mode = 1;
    run(8);
    chk("rr_count", pops.size() >= 1, 1'b1);
    if (pops.size() >= 1) chk("rr_first_pc", pops[0], 32'h0);

    // Randomized traffic with branches.
    idle();
    do_reset();
    gnt_mode = 2; resp_mode = 2; lat = 0; ready_mode = 2; br_rate = 6;
    run(3000);

    // 8-bit address wrap on the second instance.
    idle();
    do_reset();
    w_gnt = 1'b1;
    w_ready = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (w_vld) begin
        wpops.push_back(32'(w_pc));
        winstr.push_back(w_instr);
      end
      w_nxt   = w_req && w_gnt;
      w_naddr = w_addr;
      @(posedge clk);
      #1;
      w_rv    = w_nxt;
      w_rdata = 32'hAB00_0000 | 32'(w_naddr);
    end
    wexp[0] = 8'hF8; wexp[1] = 8'hFC; wexp[2] = 8'h00; wexp[3] = 8'h04;
    chk("wrap_count", wpops.size() >= 4, 1'b1);
    for (int i = 0; i < 4 && i < wpops.size(); i++) begin
      chk("wrap_pc", wpops[i], 32'(wexp[i]));
      chk("wrap_instr", winstr[i], 32'hAB00_0000 | 32'(wexp[i]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
